vm_coin_sequencer: RTL and testbench

//  Front-end controller for the vending FSM (inputs N/D, output z). Collects coin events from two

---
 rtl/vm_coin_sequencer.sv | 179 +++++++++++++++++
 tb/tb_vm_coin_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vm_coin_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vm_coin_sequencer
//  Purpose  : Front end for the vending FSM. Captures coin events from two
//             slots into a small FIFO, issues them to the vending FSM as
//             registered N/D pulses no closer than two cycles apart, catches
//             its one-cycle z and runs a req/ack handshake with the dispense
//             motor. If the motor does not answer in time, a sticky fault is
//             raised.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst              clock (rising edge), asynchronous active-low reset
//    a_nickel, a_dime      slot A coin events (1-cycle pulses)
//    b_nickel, b_dime      slot B coin events (1-cycle pulses)
//    N, D                  coin pulses to the vending FSM (5c / 10c)
//    z                     product due from the vending FSM
//    disp_req, disp_ack    dispense motor handshake
//    coin_reject           a coin event was dropped in the previous cycle
//    q_full, busy, fault   status outputs
// ============================================================================
module vm_coin_sequencer #(
  parameter int QDEPTH      = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic a_nickel,
  input  logic a_dime,
  input  logic b_nickel,
  input  logic b_dime,
  output logic N,
  output logic D,
  input  logic z,
  output logic disp_req,
  input  logic disp_ack,
  output logic coin_reject,
  output logic q_full,
  output logic busy,
  output logic fault
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT     = 3'd2,
    S_DISPENSE = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [QDEPTH-1:0] mem_q;               // 1 bit per coin: 0 nickel, 1 dime
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              n_q, n_d, d_q, d_d;
  logic              req_q, req_d;
  logic              rej_q, rej_d;
  logic              fault_q, fault_d;

  logic              w_a_ok, w_b_ok, w_a_inv, w_b_inv;
  logic              w_acc_a, w_acc_b;
  logic [CW-1:0]     w_space;
  logic [PW-1:0]     w_b_idx;
  logic              w_pop;
  logic              w_head;

  // ---------------- capture ----------------
  // Space is judged on the occupancy before this cycle's pop, so a push
  // never lands in the slot being read out.
  always_comb begin
    w_a_inv = a_nickel & a_dime;
    w_b_inv = b_nickel & b_dime;
    w_a_ok  = a_nickel ^ a_dime;
    w_b_ok  = b_nickel ^ b_dime;
    w_space = CW'(QDEPTH) - count_q;
    w_acc_a = w_a_ok && (w_space != '0);
    // B needs a second free slot when A is also pushing this cycle
    w_acc_b = w_b_ok && (w_a_ok ? (w_space >= CW'(2)) : (w_space != '0));
    rej_d   = w_a_inv | w_b_inv | (w_a_ok & ~w_acc_a) | (w_b_ok & ~w_acc_b);
    w_b_idx = w_acc_a ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + PW'(w_acc_a) + PW'(w_acc_b);
    rd_ptr_d = rd_ptr_q + PW'(w_pop);
    count_d  = count_q + CW'(w_acc_a) + CW'(w_acc_b) - CW'(w_pop);
  end

  // ---------------- issue FSM ----------------
  always_comb begin
    state_d = state_q;
    w_pop   = 1'b0;
    tmo_d   = tmo_q;
    w_head  = mem_q[rd_ptr_q];
    n_d     = 1'b0;
    d_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          w_pop   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (z) begin
          state_d = S_DISPENSE;
          tmo_d   = '0;
        end else if (count_q != '0) begin
          // no product due: issue the next coin right away, keeping the
          // two-cycle pulse spacing without an extra idle cycle
          w_pop   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DISPENSE: begin
        if (disp_ack) begin
          state_d = S_IDLE;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (w_pop) begin
      n_d = ~w_head;
      d_d = w_head;
    end
    req_d   = (state_d == S_DISPENSE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      n_q      <= 1'b0;
      d_q      <= 1'b0;
      req_q    <= 1'b0;
      rej_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (w_acc_a) mem_q[wr_ptr_q] <= a_dime;
      if (w_acc_b) mem_q[w_b_idx]  <= b_dime;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      n_q      <= n_d;
      d_q      <= d_d;
      req_q    <= req_d;
      rej_q    <= rej_d;
      fault_q  <= fault_d;
    end
  end

  assign N           = n_q;
  assign D           = d_q;
  assign disp_req    = req_q;
  assign coin_reject = rej_q;
  assign fault       = fault_q;
  assign q_full      = (count_q == CW'(QDEPTH));
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_vm_coin_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vm_coin_sequencer
//  Purpose  : Self-checking bench for vm_coin_sequencer. A queue-based
//             reference model predicts every output each cycle; issued coins
//             are pushed to a scoreboard that a monitor drains on N/D pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vm_coin_sequencer;

  localparam int QD = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_nickel = 1'b0, a_dime = 1'b0, b_nickel = 1'b0, b_dime = 1'b0;
  logic z = 1'b0, disp_ack = 1'b0;
  logic N, D, disp_req, coin_reject, q_full, busy, fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vm_coin_sequencer #(.QDEPTH(QD), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .a_nickel(a_nickel), .a_dime(a_dime), .b_nickel(b_nickel), .b_dime(b_dime),
    .N(N), .D(D), .z(z), .disp_req(disp_req), .disp_ack(disp_ack),
    .coin_reject(coin_reject), .q_full(q_full), .busy(busy), .fault(fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 coin just issued, 2 awaiting z, 3 motor running, 4 fault
  bit mq[$];          // coins waiting, 0 nickel / 1 dime
  bit expq[$];        // scoreboard: coins the DUT must present next
  bit m_new[$];
  int mode = 0, tick = 0, m_cnt = 0, m_acc = 0;
  bit m_rej, m_iss, m_coin;
  bit eN, eD, eReq, eRej, eFault;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete(); expq.delete();
      mode = 0; tick = 0;
      eN = 0; eD = 0; eReq = 0; eRej = 0; eFault = 0;
    end else begin
      m_cnt = mq.size();
      m_rej = (a_nickel && a_dime) || (b_nickel && b_dime);
      m_new.delete();
      if (a_nickel ^ a_dime) m_new.push_back(a_dime);
      if (b_nickel ^ b_dime) m_new.push_back(b_dime);
      m_iss = 0; m_coin = 0;
      case (mode)
        0: m_iss = (m_cnt > 0);
        1: mode = 2;
        2: if (z) begin mode = 3; tick = 0; end
           else if (m_cnt > 0) m_iss = 1;
           else mode = 0;
        3: if (disp_ack) mode = 0;
           else begin tick++; if (tick == TO) mode = 4; end
        default: ;
      endcase
      if (m_iss) begin
        m_coin = mq.pop_front();
        mode = 1;
        expq.push_back(m_coin);
      end
      m_acc = 0;
      foreach (m_new[i]) begin
        if (m_cnt + m_acc < QD) begin mq.push_back(m_new[i]); m_acc++; end
        else m_rej = 1;
      end
      eN = m_iss && !m_coin;
      eD = m_iss && m_coin;
      eRej = m_rej;
      eReq = (mode == 3);
      eFault = (mode == 4);
    end
  end

  // per-cycle output checks
  always @(negedge clk) begin
    chk("N", N, eN);
    chk("D", D, eD);
    chk("disp_req", disp_req, eReq);
    chk("coin_reject", coin_reject, eRej);
    chk("fault", fault, eFault);
    chk("q_full", q_full, (mq.size() == QD));
    chk("busy", busy, (mode != 0) || (mq.size() > 0));
  end

  // scoreboard monitor: every coin pulse must match the oldest expected coin
  always @(negedge clk) begin
    if (N || D) begin
      if (expq.size() == 0) begin
        chk("sb_unexpected_coin", 1, 0);
      end else begin
        chk("sb_coin_value", D, expq.pop_front());
        chk("sb_one_hot", N && D, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit an, input bit ad, input bit bn, input bit bd,
                     input bit zz, input bit ak);
    @(posedge clk); #1;
    a_nickel = an; a_dime = ad; b_nickel = bn; b_dime = bd;
    z = zz; disp_ack = ak;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    a_nickel = 0; a_dime = 0; b_nickel = 0; b_dime = 0; z = 0; disp_ack = 0;
    #1;
    chk("rst_N", N, 0); chk("rst_D", D, 0); chk("rst_req", disp_req, 0);
    chk("rst_rej", coin_reject, 0); chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 0); chk("rst_qfull", q_full, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int hi_cnt;

  initial begin
    do_reset();

    // T1: nickel then dime, product due, motor acks
    cyc(1,0,0,0,0,0);                                   // c0
    cyc(0,0,0,0,0,0); chk("t1_N_c1", N, 0);             // c1
    cyc(0,0,0,0,0,0); chk("t1_N_c2", N, 1);             // c2
    cyc(0,0,0,0,0,0); chk("t1_N_c3", N, 0);             // c3
    cyc(0,1,0,0,0,0);                                   // c4
    cyc(0,0,0,0,0,0);                                   // c5
    cyc(0,0,0,0,0,0); chk("t1_D_c6", D, 1);             // c6
    cyc(0,0,0,0,1,0); chk("t1_req_c7", disp_req, 0);    // c7
    cyc(0,0,0,0,0,0); chk("t1_req_c8", disp_req, 1);    // c8
    cyc(0,0,0,0,0,0);                                   // c9
    cyc(0,0,0,0,0,1); chk("t1_req_c10", disp_req, 1);   // c10
    cyc(0,0,0,0,0,0); chk("t1_req_c11", disp_req, 0);   // c11
    chk("t1_busy_c11", busy, 0);

    // T2: both slots in one cycle, A ahead of B
    cyc(1,0,0,1,0,0);
    cyc(0,0,0,0,0,0); chk("t2_rej", coin_reject, 0);
    cyc(0,0,0,0,0,0); chk("t2_N", N, 1);
    cyc(0,0,0,0,0,0); chk("t2_gap", N || D, 0);
    cyc(0,0,0,0,0,0); chk("t2_D", D, 1);
    repeat (3) cyc(0,0,0,0,0,0);

    // T4: invalid slot event
    cyc(1,1,0,0,0,0);
    cyc(0,0,0,0,0,0); chk("t4_rej", coin_reject, 1);
    cyc(0,0,0,0,0,0); chk("t4_busy", busy, 0);
    chk("t4_noND", N || D, 0);

    // T3 + T5: park in dispense, overfill the queue, then time out
    do_reset();
    cyc(1,0,0,0,0,0);
    cyc(0,0,0,0,0,0);
    cyc(0,0,0,0,0,0);                                   // N
    cyc(0,0,0,0,1,0);                                   // WAIT, z
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1,0,0,0,0,0);
      if (disp_req) hi_cnt++;
    end
    chk("t3_qfull", q_full, 1);
    cyc(0,0,0,0,0,0); if (disp_req) hi_cnt++;
    chk("t3_rej", coin_reject, 1);
    chk("t3_qfull_hold", q_full, 1);
    cyc(0,0,0,0,0,0); if (disp_req) hi_cnt++;
    chk("t3_rej_once", coin_reject, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0,0,0,0,0,0);
      if (disp_req) hi_cnt++;
    end
    chk("t5_req_cycles", hi_cnt, TO);
    chk("t5_fault", fault, 1);
    for (int i = 0; i < 4; i++) cyc(0,0,0,0,1,1);
    chk("t5_fault_sticky", fault, 1);
    chk("t5_req_low", disp_req, 0);

    // T6: reset in the middle of a dispense with coins queued
    do_reset();
    cyc(1,0,0,0,0,0);
    cyc(0,0,0,0,0,0);
    cyc(0,0,0,0,0,0);
    cyc(0,0,0,0,1,0);
    cyc(0,1,0,0,0,0);
    cyc(1,0,0,0,0,0);
    cyc(0,0,0,0,0,0);
    chk("t6_req_before", disp_req, 1);
    @(posedge clk); #3;
    a_nickel = 0; a_dime = 0; b_nickel = 0; b_dime = 0; z = 0; disp_ack = 0;
    rst = 1'b0;
    #1 chk("t6_req_cut", disp_req, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0,0,0,0,0,0);
      chk("t6_busy", busy, 0);
      chk("t6_noND", N || D, 0);
    end

    // randomized episodes, each started from reset
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        cyc($urandom_range(0, ep % 2 ? 1 : 4) == 0,
            $urandom_range(0, ep % 2 ? 1 : 4) == 0,
            $urandom_range(0, ep % 2 ? 1 : 4) == 0,
            $urandom_range(0, ep % 2 ? 1 : 4) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0);
      end
      for (int c = 0; c < 4; c++) cyc(0,0,0,0,0,1);
      #1 chk("sb_drained", expq.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
